uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 14 +
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_tx_fifo.sv | 85 ++++++++
 tb/tb_uart_tx_fifo.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and types for the UART transmit FIFO and its siblings.
// The byte width and baud divider are kept here so every UART block agrees on them.
package uart_tx_fifo_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_CNT = 625;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Byte FIFO: register-array storage, wrapping pointers and a registered occupancy count.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              push,
    input  logic              pop,
    output logic [BYTE_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count,
    output logic              push_ok
);

    localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_ok;

    // A pop on an empty FIFO is ignored, so a same-cycle push never bypasses storage.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10: begin
                    count <= count + 1'b1;
                    full  <= (count == DEPTH_M1);
                    empty <= 1'b0;
                end
                2'b01: begin
                    count <= count - 1'b1;
                    full  <= 1'b0;
                    empty <= (count == (AW+1)'(1));
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of a UART transmitter: buffers producer bytes and drains them
// one at a time with a single-cycle start pulse whenever the transmitter reports idle.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [BYTE_W-1:0] D,
    input  logic              EN,
    output logic              FULL,
    output logic              EMPTY,
    output logic [AW:0]       COUNT,
    output logic              OVF,
    output logic [BYTE_W-1:0] TX_D,
    output logic              TX_EN,
    input  logic              TX_RDY,
    output logic [1:0]        fsm_state
);

    drain_state_t      state;
    drain_state_t      state_next;
    logic              pop;
    logic              tx_en_next;
    logic              push_ok;
    logic [BYTE_W-1:0] head;

    sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST_N),
        .push_data (D),
        .push      (EN),
        .pop       (pop),
        .head      (head),
        .full      (FULL),
        .empty     (EMPTY),
        .count     (COUNT),
        .push_ok   (push_ok)
    );

    // ISSUE carries the start pulse; HOLD covers the cycle before the transmitter drops RDY.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        tx_en_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!EMPTY && TX_RDY) begin
                    pop        = 1'b1;
                    tx_en_next = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_HOLD;
            ST_HOLD:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            TX_EN <= 1'b0;
            TX_D  <= '0;
            OVF   <= 1'b0;
        end else begin
            state <= state_next;
            TX_EN <= tx_en_next;
            if (pop) begin
                TX_D <= head;
            end
            if (EN && !push_ok) begin
                OVF <= 1'b1;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: hand-derived vector table, corner-case sequences
// and randomized traffic compared against a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [7:0]    D = 8'h00;
    logic          EN = 1'b0;
    logic          TX_RDY = 1'b0;
    logic          FULL;
    logic          EMPTY;
    logic [AW:0]   COUNT;
    logic          OVF;
    logic [7:0]    TX_D;
    logic          TX_EN;
    logic [1:0]    fsm_state;

    uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .D         (D),
        .EN        (EN),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT),
        .OVF       (OVF),
        .TX_D      (TX_D),
        .TX_EN     (TX_EN),
        .TX_RDY    (TX_RDY),
        .fsm_state (fsm_state)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    // Reference model: bytes waiting, pop spacing, sticky overflow, last handed-out byte.
    logic [7:0] exp_q[$];
    int         m_cool;
    logic       m_ovf;
    logic       m_txen;
    logic [7:0] m_txd;
    int         sent;
    logic [7:0] last_sent;

    typedef struct {
        logic       en;
        logic [7:0] d;
        logic       rdy;
        int         cnt;
        logic       txen;
        logic [7:0] txd;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_cool = 0;
        m_ovf  = 1'b0;
        m_txen = 1'b0;
        m_txd  = 8'h00;
    endtask

    // One clock: drive inputs, advance the model, then compare all outputs after the edge.
    task automatic cycle(input logic en, input logic [7:0] d, input logic rdy);
        logic pop;
        logic acc;
        EN     = en;
        D      = d;
        TX_RDY = rdy;
        pop    = 1'b0;
        if (m_cool > 0) m_cool--;
        else if (exp_q.size() > 0 && rdy) pop = 1'b1;
        acc    = en && (exp_q.size() < DEPTH || pop);
        m_txen = pop;
        if (pop) begin
            m_txd  = exp_q.pop_front();
            m_cool = 2;
        end
        if (en && !acc) m_ovf = 1'b1;
        if (acc) exp_q.push_back(d);
        @(posedge CLK);
        #1;
        chk("count", int'(COUNT), exp_q.size());
        chk("full", int'(FULL), int'(exp_q.size() == DEPTH));
        chk("empty", int'(EMPTY), int'(exp_q.size() == 0));
        chk("ovf", int'(OVF), int'(m_ovf));
        chk("tx_en", int'(TX_EN), int'(m_txen));
        chk("tx_d", int'(TX_D), int'(m_txd));
        if (TX_EN) begin
            sent++;
            last_sent = TX_D;
        end
    endtask

    task automatic do_reset();
        EN     = 1'b0;
        TX_RDY = 1'b0;
        RST_N  = 1'b0;
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("rst_count", int'(COUNT), 0);
        chk("rst_empty", int'(EMPTY), 1);
        chk("rst_full", int'(FULL), 0);
        chk("rst_ovf", int'(OVF), 0);
        chk("rst_tx_en", int'(TX_EN), 0);
        chk("rst_tx_d", int'(TX_D), 0);
        chk("rst_state", int'(fsm_state), 0);
        RST_N = 1'b1;
        sent  = 0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h41, 1'b1, 1, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h41};
        vecs[2] = '{1'b1, 8'h42, 1'b1, 1, 1'b0, 8'h41};
        vecs[3] = '{1'b1, 8'h43, 1'b1, 2, 1'b0, 8'h41};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 2, 1'b0, 8'h41};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h42};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h42};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h42};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 8'h43};
        vecs[9] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h43};

        sent = 0;
        last_sent = 8'h00;

        // Single byte latency and short back-to-back traffic.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].en, vecs[i].d, vecs[i].rdy);
            chk("tbl_count", int'(COUNT), vecs[i].cnt);
            chk("tbl_tx_en", int'(TX_EN), int'(vecs[i].txen));
            chk("tbl_tx_d", int'(TX_D), int'(vecs[i].txd));
        end

        // Fill with the transmitter busy, overflow once, then drain.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 8'(8'h80 + i), 1'b0);
            if (i == 15) begin
                chk("fill_full", int'(FULL), 1);
                chk("fill_count", int'(COUNT), 16);
                chk("fill_ovf", int'(OVF), 0);
            end
        end
        chk("ovf_set", int'(OVF), 1);
        chk("ovf_count", int'(COUNT), 16);
        drain(60);
        chk("ovf_drained", int'(COUNT), 0);
        chk("ovf_sticky", int'(OVF), 1);
        chk("ovf_sent", sent, 16);
        chk("ovf_last", int'(last_sent), 8'h8f);

        // Full FIFO with a write in the same cycle as a pop.
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'h55, 1'b1);
        chk("fp_count", int'(COUNT), 16);
        chk("fp_ovf", int'(OVF), 0);
        chk("fp_tx_en", int'(TX_EN), 1);
        chk("fp_tx_d", int'(TX_D), 0);
        drain(60);
        chk("fp_sent", sent, 17);
        chk("fp_last", int'(last_sent), 8'h55);

        // Asynchronous reset while the start pulse is high.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("md_tx_en", int'(TX_EN), 1);
        chk("md_count", int'(COUNT), 5);
        #2;
        RST_N = 1'b0;
        #1;
        chk("md_rst_tx_en", int'(TX_EN), 0);
        chk("md_rst_count", int'(COUNT), 0);
        chk("md_rst_empty", int'(EMPTY), 1);
        chk("md_rst_tx_d", int'(TX_D), 0);
        model_reset();
        EN = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        sent  = 0;
        drain(12);
        chk("md_no_stale", sent, 0);

        // Randomized traffic with transmitter stalls, long enough to wrap the pointers.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 35), 8'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        drain(80);
        chk("rnd_drained", int'(COUNT), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
